counting_sort_stream: RTL and testbench

//  Streaming counting sorter. Accepts batches of DATA_SIZE unsigned keys on a

---
 rtl/counting_sort_pkg.sv | 16 +
 rtl/counting_sort_stream_count_bank.sv | 37 +++
 rtl/counting_sort_stream.sv | 126 ++++++++++++
 tb/tb_counting_sort_stream.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/counting_sort_pkg.sv
// Shared types and helpers for the streaming counting sorter.
// Scan direction is selected with COUNTING_SORT_DESCENDING_EN, which the top level uses.
package counting_sort_pkg;

  // Controller phases: the batch is collected in LOAD and emitted in EMIT.
  typedef enum logic {
    LOAD = 1'b0,
    EMIT = 1'b1
  } state_e;

  // A bin must be able to hold a count from 0 to size inclusive.
  function automatic int unsigned cnt_width(input int unsigned size);
    return $clog2(size + 1);
  endfunction

endpackage

// File: rtl/counting_sort_stream_count_bank.sv
// count_bank: NUM_BINS x CNT_W histogram register file.
// Increments and decrements happen on separate ports. The read is combinational,
// and a synchronous clear zeroes every bin.
module count_bank
  import counting_sort_pkg::*;
#(
  parameter int unsigned NUM_BINS = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned CNT_W    = 3
) (
  input  logic              clk_i,
  input  logic              clr_i,
  input  logic              inc_en_i,
  input  logic [ADDR_W-1:0] inc_addr_i,
  input  logic              dec_en_i,
  input  logic [ADDR_W-1:0] dec_addr_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [CNT_W-1:0]  rd_data_o
);

  logic [CNT_W-1:0] bins_q [NUM_BINS];

  // Histogram update: the clear has priority, then the increment or the decrement.
  // NOTE: the whole bank is cleared on reset. An interrupted batch would otherwise
  // leave nonzero bins that corrupt the next batch, because there is no clear phase.
  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      bins_q <= '{default: '0};
    end else begin
      if (inc_en_i) bins_q[inc_addr_i] <= bins_q[inc_addr_i] + CNT_W'(1);
      if (dec_en_i) bins_q[dec_addr_i] <= bins_q[dec_addr_i] - CNT_W'(1);
    end
  end

  assign rd_data_o = bins_q[rd_addr_i];

endmodule

// File: rtl/counting_sort_stream.sv
// counting_sort_stream: builds a histogram of a DATA_SIZE-key batch, then emits
// the keys in sorted order. Each bin drains to zero as its keys are emitted.
// Define COUNTING_SORT_DESCENDING_EN to scan bins from high to low, which gives
// non-increasing output.
module counting_sort_stream
  import counting_sort_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 5,
  parameter int unsigned DATA_SIZE  = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  write_valid_i,
  output logic                  write_ready_o,
  input  logic [DATA_WIDTH-1:0] write_data_i,
  input  logic                  read_ready_i,
  output logic                  read_valid_o,
  output logic [DATA_WIDTH-1:0] read_data_o,
  output logic                  read_last_o
);

  localparam int unsigned NUM_BINS = 1 << DATA_WIDTH;
  localparam int unsigned CNT_W    = cnt_width(DATA_SIZE);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_SIZE - 1);

`ifdef COUNTING_SORT_DESCENDING_EN
  localparam logic [DATA_WIDTH-1:0] FIRST_BIN = DATA_WIDTH'(NUM_BINS - 1);
`else
  localparam logic [DATA_WIDTH-1:0] FIRST_BIN = '0;
`endif

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      in_cnt_q, in_cnt_d;
  logic [CNT_W-1:0]      out_cnt_q, out_cnt_d;
  logic [DATA_WIDTH-1:0] bin_q, bin_d;
  logic [DATA_WIDTH-1:0] bin_step;
  logic [CNT_W-1:0]      bin_cnt;
  logic                  wr_hs;
  logic                  rd_hs;

  // The scan never runs past the last bin, so a plain step is enough.
`ifdef COUNTING_SORT_DESCENDING_EN
  assign bin_step = bin_q - DATA_WIDTH'(1);
`else
  assign bin_step = bin_q + DATA_WIDTH'(1);
`endif

  count_bank #(
    .NUM_BINS (NUM_BINS),
    .ADDR_W   (DATA_WIDTH),
    .CNT_W    (CNT_W)
  ) u_bank (
    .clk_i      (clk_i),
    .clr_i      (rst_i),
    .inc_en_i   (wr_hs),
    .inc_addr_i (write_data_i),
    .dec_en_i   (rd_hs),
    .dec_addr_i (bin_q),
    .rd_addr_i  (bin_q),
    .rd_data_o  (bin_cnt)
  );

  // Handshakes and port outputs. Writes and reads are exclusive by state.
  always_comb begin
    write_ready_o = (state_q == LOAD);
    read_valid_o  = (state_q == EMIT) && (bin_cnt != '0);
    read_data_o   = (state_q == EMIT) ? bin_q : '0;
    read_last_o   = read_valid_o && (out_cnt_q == LAST_CNT);
    wr_hs         = write_valid_i && write_ready_o;
    rd_hs         = read_valid_o && read_ready_i;
  end

  // Next state: count keys in, then walk the bins and drain them.
  // NOTE: every next-state signal defaults to its current value first, so no
  // path through the case leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    in_cnt_d  = in_cnt_q;
    out_cnt_d = out_cnt_q;
    bin_d     = bin_q;
    unique case (state_q)
      LOAD: begin
        if (wr_hs) begin
          if (in_cnt_q == LAST_CNT) begin
            in_cnt_d = '0;
            state_d  = EMIT;
          end else begin
            in_cnt_d = in_cnt_q + CNT_W'(1);
          end
        end
      end
      EMIT: begin
        if (bin_cnt == '0) begin
          bin_d = bin_step;
        end else if (rd_hs) begin
          if (out_cnt_q == LAST_CNT) begin
            out_cnt_d = '0;
            bin_d     = FIRST_BIN;
            state_d   = LOAD;
          end else begin
            out_cnt_d = out_cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = LOAD;
    endcase
  end

  // State registers with synchronous reset.
  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the values from before the edge, whatever order the statements are in.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= LOAD;
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
      bin_q     <= FIRST_BIN;
    end else begin
      state_q   <= state_d;
      in_cnt_q  <= in_cnt_d;
      out_cnt_q <= out_cnt_d;
      bin_q     <= bin_d;
    end
  end

endmodule

// File: tb/tb_counting_sort_stream.sv
// Directed bench for counting_sort_stream (DATA_WIDTH=5, DATA_SIZE=4).
// The expected order comes from a local sort that follows COUNTING_SORT_DESCENDING_EN.
module tb_counting_sort_stream;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       write_valid_i = 1'b0;
  logic       write_ready_o;
  logic [4:0] write_data_i = '0;
  logic       read_ready_i = 1'b1;
  logic       read_valid_o;
  logic [4:0] read_data_o;
  logic       read_last_o;

  int n_checks = 0;
  int n_pass   = 0;

  counting_sort_stream #(.DATA_WIDTH(5), .DATA_SIZE(4)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .write_valid_i (write_valid_i),
    .write_ready_o (write_ready_o),
    .write_data_i  (write_data_i),
    .read_ready_i  (read_ready_i),
    .read_valid_o  (read_valid_o),
    .read_data_o   (read_data_o),
    .read_last_o   (read_last_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Reference order for a batch of four keys.
  function automatic logic [3:0][4:0] sort_keys(input logic [3:0][4:0] k);
    logic [3:0][4:0] s;
    logic [4:0]      t;
    s = k;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 3; j++) begin
`ifdef COUNTING_SORT_DESCENDING_EN
        if (s[j] < s[j+1]) begin
`else
        if (s[j] > s[j+1]) begin
`endif
          t = s[j]; s[j] = s[j+1]; s[j+1] = t;
        end
      end
    end
    return s;
  endfunction

  // Call and return on a falling edge.
  task automatic write_batch(input string tag, input logic [3:0][4:0] k);
    for (int i = 0; i < 4; i++) begin
      write_valid_i = 1'b1;
      write_data_i  = k[i];
      check({tag, "_wready"}, write_ready_o, 1);
      @(posedge clk_i);
      @(negedge clk_i);
    end
    write_valid_i = 1'b0;
  endtask

  // Waits (bounded) for valid, checks data and last, then completes the handshake.
  task automatic read_key(input string tag, input logic [4:0] exp_d, input logic exp_l);
    int n;
    n = 0;
    read_ready_i = 1'b1;
    while (!read_valid_o && n < 64) begin
      @(negedge clk_i);
      n++;
    end
    check({tag, "_valid"}, read_valid_o, 1);
    check({tag, "_data"}, read_data_o, exp_d);
    check({tag, "_last"}, read_last_o, exp_l);
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic read_batch(input string tag, input logic [3:0][4:0] k);
    logic [3:0][4:0] s;
    s = sort_keys(k);
    for (int i = 0; i < 4; i++) read_key(tag, s[i], i == 3);
  endtask

  initial begin
    logic [3:0][4:0] b;
    logic [3:0][4:0] s;
    int n;

    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;

    // 1: reset state, then a small mixed batch
    check("rst_wready", write_ready_o, 1);
    check("rst_rvalid", read_valid_o, 0);
    check("rst_rdata", read_data_o, 0);
    check("rst_rlast", read_last_o, 0);
    b = {5'd0, 5'd2, 5'd1, 5'd3};
    write_batch("t1w", b);
    read_batch("t1r", b);

    // 2: all keys equal; measure the first-output latency from EMIT entry
    b = {5'd7, 5'd7, 5'd7, 5'd7};
    write_batch("t2w", b);
    check("t2_entry_wready", write_ready_o, 0);
    n = 0;
    while (!read_valid_o && n < 64) begin
      @(negedge clk_i);
      n++;
    end
`ifdef COUNTING_SORT_DESCENDING_EN
    check("t2_latency", n, 24);
`else
    check("t2_latency", n, 7);
`endif
    read_batch("t2r", b);

    // 3: consumer stalls; valid and data must hold
    b = {5'd4, 5'd9, 5'd4, 5'd9};
    s = sort_keys(b);
    read_ready_i = 1'b0;
    write_batch("t3w", b);
    n = 0;
    while (!read_valid_o && n < 64) begin
      @(negedge clk_i);
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      check("t3_hold_valid", read_valid_o, 1);
      check("t3_hold_data", read_data_o, s[0]);
      @(negedge clk_i);
    end
    read_batch("t3r", b);

    // 4: extreme keys, then a back-to-back batch
    b = {5'd0, 5'd31, 5'd0, 5'd31};
    write_batch("t4w", b);
    read_batch("t4r", b);
    check("t4_wready_after_last", write_ready_o, 1);
    check("t4_rvalid_after_last", read_valid_o, 0);
    b = {5'd2, 5'd2, 5'd2, 5'd2};
    write_batch("t4bw", b);
    read_batch("t4br", b);

    // 5: reset in the middle of emission; no stale counts may survive
    b = {5'd3, 5'd4, 5'd5, 5'd6};
    s = sort_keys(b);
    write_batch("t5w", b);
    read_key("t5r0", s[0], 1'b0);
    read_key("t5r1", s[1], 1'b0);
    rst_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    check("t5_rst_wready", write_ready_o, 1);
    check("t5_rst_rvalid", read_valid_o, 0);
    rst_i = 1'b0;
    b = {5'd0, 5'd0, 5'd1, 5'd1};
    write_batch("t5bw", b);
    read_batch("t5br", b);
    check("t5_wready_after_last", write_ready_o, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected completion");
    $fatal(1, "bench timeout");
  end

endmodule
